// File: rtl/pid_step_sequencer.sv
// pid_step_sequencer: one PID step per sample tick or start pulse. A single external
// signed multiplier is shared across the P, I and D terms; the scaled sum is saturated to 8 bits.
`timescale 1ns/1ps
module pid_step_sequencer #(
  parameter int unsigned DIV     = 256,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned INT_LIM = 4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic [7:0]         setpoint,
  input  logic [7:0]         measure,
  input  logic [7:0]         kp,
  input  logic [7:0]         ki,
  input  logic [7:0]         kd,
  output logic [15:0]        mul_a,
  output logic [7:0]         mul_b,
  input  logic signed [23:0] mul_p,
  output logic [7:0]         ctrl_out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic signed [16:0] LIM = 17'(INT_LIM);

  typedef enum logic [2:0] {IDLE, CALC, MUL_P, MUL_I, MUL_D, SUM} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic               tick_q;
  logic               trigger;
  logic signed [8:0]  e_q, e_n, e_c;
  logic signed [9:0]  de_q, de_n, de_c;
  logic signed [15:0] integ, integ_n, integ_c;
  logic signed [16:0] isum;
  logic [7:0]         ki_q, ki_n, kd_q, kd_n;
  logic signed [25:0] acc, acc_n, mul_ext, y_c;
  logic [15:0]        mul_a_n;
  logic [7:0]         mul_b_n, ctrl_n;
  logic               valid_n, ovr_n, busy_n;

  assign trigger = tick_q | start;
  assign e_c     = $signed({1'b0, setpoint}) - $signed({1'b0, measure});
  assign de_c    = $signed({e_c[8], e_c}) - $signed({e_q[8], e_q});
  assign isum    = $signed({integ[15], integ}) + $signed({{8{e_c[8]}}, e_c});
  assign mul_ext = $signed({{2{mul_p[23]}}, mul_p});
  assign y_c     = acc >>> SHIFT;

  // Integral clamp to +-INT_LIM
  always_comb begin
    integ_c = 16'(isum);
    if (isum > LIM)       integ_c = 16'(LIM);
    else if (isum < -LIM) integ_c = 16'(-LIM);
  end

  // Sample-rate prescaler; tick is registered so the first one lands DIV cycles after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (ena) begin
        if (cnt == CW'(DIV - 1)) begin
          cnt    <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Next-state, datapath and output decode; multiplier operands are staged one state ahead
  always_comb begin
    state_n = state;
    e_n     = e_q;
    de_n    = de_q;
    integ_n = integ;
    ki_n    = ki_q;
    kd_n    = kd_q;
    acc_n   = acc;
    mul_a_n = '0;
    mul_b_n = '0;
    ctrl_n  = ctrl_out;
    valid_n = 1'b0;
    ovr_n   = overrun;
    case (state)
      IDLE: if (trigger) state_n = CALC;
      CALC: begin
        e_n     = e_c;
        de_n    = de_c;
        integ_n = integ_c;
        ki_n    = ki;
        kd_n    = kd;
        mul_a_n = {{7{e_c[8]}}, e_c};
        mul_b_n = kp;
        state_n = MUL_P;
      end
      MUL_P: begin
        acc_n   = mul_ext;
        mul_a_n = integ;
        mul_b_n = ki_q;
        state_n = MUL_I;
      end
      MUL_I: begin
        acc_n   = acc + mul_ext;
        mul_a_n = {{6{de_q[9]}}, de_q};
        mul_b_n = kd_q;
        state_n = MUL_D;
      end
      MUL_D: begin
        acc_n   = acc + mul_ext;
        state_n = SUM;
      end
      SUM: begin
        if (y_c[25])         ctrl_n = 8'd0;
        else if (|y_c[24:8]) ctrl_n = 8'd255;
        else                 ctrl_n = y_c[7:0];
        valid_n = 1'b1;
        state_n = trigger ? CALC : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (trigger && state != IDLE && state != SUM) ovr_n = 1'b1;
    busy_n = (state_n != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      e_q       <= '0;
      de_q      <= '0;
      integ     <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      ctrl_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      e_q       <= e_n;
      de_q      <= de_n;
      integ     <= integ_n;
      ki_q      <= ki_n;
      kd_q      <= kd_n;
      acc       <= acc_n;
      mul_a     <= mul_a_n;
      mul_b     <= mul_b_n;
      ctrl_out  <= ctrl_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      overrun   <= ovr_n;
    end
  end

endmodule

// File: tb/tb_pid_step_sequencer.sv
// Directed bench for pid_step_sequencer: main instance, INT_LIM=25 instance, DIV=8 instance.
`timescale 1ns/1ps
module tb_pid_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b, start, start_b;
  logic [7:0] sp, meas, kp, ki, kd;
  int total = 0;
  int bad   = 0;

  logic [15:0] mul_a_a, mul_a_c, mul_a_b;
  logic [7:0]  mul_b_a, mul_b_c, mul_b_b;
  logic signed [23:0] mul_p_a, mul_p_c, mul_p_b;
  logic [7:0]  ctrl_a, ctrl_c, ctrl_b;
  logic        ov_a, ov_c, ov_b, busy_a, busy_c, busy_b, ovr_a, ovr_c, ovr_b;

  // External multipliers: signed operand times unsigned gain
  assign mul_p_a = $signed({{8{mul_a_a[15]}}, mul_a_a}) * $signed({16'd0, mul_b_a});
  assign mul_p_c = $signed({{8{mul_a_c[15]}}, mul_a_c}) * $signed({16'd0, mul_b_c});
  assign mul_p_b = $signed({{8{mul_a_b[15]}}, mul_a_b}) * $signed({16'd0, mul_b_b});

  pid_step_sequencer u_a (
    .clk(clk), .rst(rst), .ena(1'b0), .start(start), .setpoint(sp), .measure(meas),
    .kp(kp), .ki(ki), .kd(kd), .mul_a(mul_a_a), .mul_b(mul_b_a), .mul_p(mul_p_a),
    .ctrl_out(ctrl_a), .out_valid(ov_a), .busy(busy_a), .overrun(ovr_a));

  pid_step_sequencer #(.INT_LIM(25)) u_c (
    .clk(clk), .rst(rst), .ena(1'b0), .start(start), .setpoint(sp), .measure(meas),
    .kp(kp), .ki(ki), .kd(kd), .mul_a(mul_a_c), .mul_b(mul_b_c), .mul_p(mul_p_c),
    .ctrl_out(ctrl_c), .out_valid(ov_c), .busy(busy_c), .overrun(ovr_c));

  pid_step_sequencer #(.DIV(8)) u_b (
    .clk(clk), .rst(rst_b), .ena(1'b1), .start(start_b), .setpoint(sp), .measure(meas),
    .kp(kp), .ki(ki), .kd(kd), .mul_a(mul_a_b), .mul_b(mul_b_b), .mul_p(mul_p_b),
    .ctrl_out(ctrl_b), .out_valid(ov_b), .busy(busy_b), .overrun(ovr_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One start-triggered step on u_a/u_c with latency, operand and result checks
  task automatic run_step(input string tag, input logic [7:0] exp_a, input logic [7:0] exp_c);
    int e;
    e = int'(sp) - int'(meas);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      chk({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
      chk({tag, "_nov"}, {31'd0, ov_a}, 32'd0);
      cyc();
      if (k == 2) begin
        chk({tag, "_mula"}, {16'd0, mul_a_a}, {16'd0, 16'(e)});
        chk({tag, "_mulb"}, {24'd0, mul_b_a}, {24'd0, kp});
      end
    end
    chk({tag, "_ov"}, {31'd0, ov_a}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_ctrl"}, {24'd0, ctrl_a}, {24'd0, exp_a});
    chk({tag, "_ctrl_lim"}, {24'd0, ctrl_c}, {24'd0, exp_c});
    cyc();
    chk({tag, "_ovlow"}, {31'd0, ov_a}, 32'd0);
    chk({tag, "_hold"}, {24'd0, ctrl_a}, {24'd0, exp_a});
  endtask

  initial begin
    bit seen;
    rst = 1'b1; rst_b = 1'b1; start = 1'b0; start_b = 1'b0;
    sp = 8'd0; meas = 8'd0; kp = 8'd0; ki = 8'd0; kd = 8'd0;
    cyc(); cyc();
    rst = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("rst_ctrl", {24'd0, ctrl_a}, 32'd0);
    chk("rst_mula", {16'd0, mul_a_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_ovr", {31'd0, ovr_b}, 32'd0);

    // Prescaler: DIV=8, out_valid after edges 14 and 22
    for (int k = 1; k <= 23; k++) begin
      cyc();
      chk($sformatf("tick_ov%0d", k), {31'd0, ov_b}, {31'd0, (k == 14 || k == 22)});
    end

    // Start while busy -> overrun sticky
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (busy_b) seen = 1'b1;
      else cyc();
    end
    chk("busy_b_seen", {31'd0, seen}, 32'd1);
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    chk("ovr_set", {31'd0, ovr_b}, 32'd1);
    for (int k = 0; k < 10; k++) cyc();
    chk("ovr_sticky", {31'd0, ovr_b}, 32'd1);

    // Proportional
    kp = 8'd16; sp = 8'd100; meas = 8'd40;
    run_step("p_pos", 8'd60, 8'd60);
    sp = 8'd40; meas = 8'd100;
    run_step("p_neg", 8'd0, 8'd0);
    kp = 8'd255; sp = 8'd255; meas = 8'd0;
    run_step("p_sat", 8'd255, 8'd255);

    // Reset in MUL_I aborts the step
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    chk("abort_ctrl", {24'd0, ctrl_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_mula", {16'd0, mul_a_a}, 32'd0);
    chk("abort_mulb", {24'd0, mul_b_a}, 32'd0);
    cyc();
    chk("abort_ov", {31'd0, ov_a}, 32'd0);
    rst = 1'b0;
    cyc();

    // Integral from a fresh state, normal and clamped
    kp = 8'd0; ki = 8'd16; kd = 8'd0; sp = 8'd60; meas = 8'd50;
    run_step("i_1", 8'd10, 8'd10);
    run_step("i_2", 8'd20, 8'd20);
    run_step("i_3", 8'd30, 8'd25);
    run_step("i_4", 8'd40, 8'd25);

    // Derivative
    ki = 8'd0; kd = 8'd16; sp = 8'd50; meas = 8'd50;
    run_step("d_0", 8'd0, 8'd0);
    sp = 8'd70;
    run_step("d_step", 8'd20, 8'd20);
    run_step("d_flat", 8'd0, 8'd0);

    // Trigger during SUM is accepted without overrun
    kp = 8'd16; kd = 8'd0; sp = 8'd100; meas = 8'd40;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 2; k <= 5; k++) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("b2b_ov1", {31'd0, ov_a}, 32'd1);
    chk("b2b_busy", {31'd0, busy_a}, 32'd1);
    for (int k = 7; k <= 11; k++) cyc();
    chk("b2b_ov2", {31'd0, ov_a}, 32'd1);
    chk("b2b_ctrl", {24'd0, ctrl_a}, 32'd60);
    chk("b2b_novr", {31'd0, ovr_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
